// File: rtl/pipe_seg_adder_pkg.sv
// Shared geometry for the segmented pipelined adder: defaults, stage count helper, geometry check.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_seg_adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 8;

    // One pipeline stage per SEG-bit segment.
    function automatic int calc_stages(input int width, input int seg);
        return width / seg;
    endfunction

    // Legal geometry: at least one bit per stage, width an exact multiple of the segment.
    function automatic bit geometry_ok(input int width, input int seg);
        return (seg >= 1) && (width >= seg) && (width % seg == 0);
    endfunction

endpackage

// File: rtl/pipe_seg_adder_if.sv
// Operand/result handshake bundle for pipe_seg_adder.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry valid-ready flow control in each direction.
//   slave  : the adder (takes operands, presents results)
//   master : the operand source / result sink
interface pipe_seg_adder_if
    import pipe_seg_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/pipe_seg_adder_stage.sv
// One SEG-bit adder slice with its own valid register and skid-free stage handshake.
// Latency: 1 cycle (registered sum, carry out and carry into the segment MSB).
// Backpressure: in_ready = !out_valid || out_ready; holds its outputs while stalled.
//   in_valid/in_ready/a/b/ci : upstream beat;  out_valid/out_ready/s/co/cm : registered result
//   load : high on the edge that captures a new beat (used by the top for side registers)
module seg_add_stage #(
    parameter int SEG = 8
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           cm,
    output logic           load
);

    logic [SEG:0] full;
    logic         carry_msb;

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    assign full      = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
    // Carry into the slice MSB, recovered from the MSB sum bit.
    assign carry_msb = a[SEG-1] ^ b[SEG-1] ^ full[SEG-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            s         <= '0;
            co        <= 1'b0;
            cm        <= 1'b0;
        end else begin
            // An empty or draining stage takes whatever is offered (bubbles collapse).
            if (in_ready) begin
                out_valid <= in_valid;
            end
            if (load) begin
                {co, s} <= full;
                cm      <= carry_msb;
            end
        end
    end

endmodule

// File: rtl/pipe_seg_adder.sv
// Pipelined WIDTH-bit adder with carry-in, one SEG-bit segment per stage, carry rippling through registers.
// Latency: STAGES cycles; one beat per cycle sustained.
// Backpressure: per-stage ready chain; in_ready is combinational from out_ready through the chain.
//   clk, resetn : clock and asynchronous active-low reset
//   bus         : operand in (in_valid/in_ready, a, b, cin), result out (out_valid/out_ready, sum, cout, ovf)
module pipe_seg_adder
    import pipe_seg_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic            clk,
    input  logic            resetn,
    pipe_seg_adder_if.slave bus
);

    localparam int STAGES = calc_stages(WIDTH, SEG);

    if (!geometry_ok(WIDTH, SEG)) begin : g_bad_geometry
        $error("pipe_seg_adder: WIDTH must be a non-zero multiple of SEG, and SEG >= 1");
    end

    // vld[k]/rdy[k] is the handshake into stage k; index STAGES is the output port.
    logic [STAGES:0]   vld;
    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] ci;
    logic [STAGES-1:0] co;
    logic [STAGES-1:0] cm;
    logic [SEG-1:0]    seg_a [STAGES];
    logic [SEG-1:0]    seg_b [STAGES];
    logic [SEG-1:0]    seg_s [STAGES];
    // Operands as seen by stage k, shifted so segment k sits at the LSBs.
    logic [WIDTH-1:0]  opa [STAGES];
    logic [WIDTH-1:0]  opb [STAGES];
    // Sum bits finished at the output of stage k, already in final bit positions.
    logic [WIDTH-1:0]  acc [STAGES];

    assign vld[0]         = bus.in_valid;
    assign bus.in_ready   = rdy[0];
    assign rdy[STAGES]    = bus.out_ready;
    assign bus.out_valid  = vld[STAGES];
    assign bus.sum        = acc[STAGES-1];
    assign bus.cout       = co[STAGES-1];
    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign bus.ovf        = co[STAGES-1] ^ cm[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign opa[0] = bus.a;
            assign opb[0] = bus.b;
            assign ci[0]  = bus.cin;
            assign acc[0] = WIDTH'(seg_s[0]);
        end else begin : g_body
            // opa_q/opb_q load alongside stage k-1 (the untouched upper operand bits);
            // lo_q loads alongside stage k (the lower sum bits already finished upstream).
            logic [WIDTH-1:0] opa_q;
            logic [WIDTH-1:0] opb_q;
            logic [WIDTH-1:0] lo_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    opa_q <= '0;
                    opb_q <= '0;
                    lo_q  <= '0;
                end else begin
                    if (load[k-1]) begin
                        opa_q <= opa[k-1] >> SEG;
                        opb_q <= opb[k-1] >> SEG;
                    end
                    if (load[k]) begin
                        lo_q <= acc[k-1];
                    end
                end
            end

            assign opa[k] = opa_q;
            assign opb[k] = opb_q;
            assign ci[k]  = co[k-1];
            assign acc[k] = lo_q | (WIDTH'(seg_s[k]) << (k * SEG));
        end

        assign seg_a[k] = opa[k][SEG-1:0];
        assign seg_b[k] = opb[k][SEG-1:0];

        seg_add_stage #(
            .SEG (SEG)
        ) u_stage (
            .clk       (clk),
            .resetn    (resetn),
            .in_valid  (vld[k]),
            .in_ready  (rdy[k]),
            .a         (seg_a[k]),
            .b         (seg_b[k]),
            .ci        (ci[k]),
            .out_valid (vld[k+1]),
            .out_ready (rdy[k+1]),
            .s         (seg_s[k]),
            .co        (co[k]),
            .cm        (cm[k]),
            .load      (load[k])
        );
    end

endmodule
